// File: rtl/cpu_clk_ctrl.sv
// cpu_clk_ctrl: divides clk_in into the 6502 phi2 clock with a programmable divisor,
// high-phase stretching and run/halt/single-step sequencing.
module cpu_clk_ctrl #(
    parameter int DIV_WIDTH   = 4,
    parameter int DEFAULT_DIV = 12,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 step_req,
    output logic                 step_ack,
    input  logic                 div_load,
    input  logic [DIV_WIDTH-1:0] div_value,
    input  logic                 stretch,
    output logic                 phi2,
    output logic                 phi2_rise,
    output logic                 phi2_fall,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] cycle_count
);
    typedef enum logic [1:0] {HALT, RUN, STEP} state_t;
    localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
    state_t               state_q;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, pend_q, pend_d;
    logic [CNT_WIDTH-1:0] cyc_q;
    logic                 phi2_q, phi2_d, rise_q, fall_q, ack_q, halted_q;
    logic                 last, done;
    always_comb begin
        pend_d = div_load ? (div_value < TWO ? TWO : div_value) : pend_q;
        last   = cnt_q == div_q - ONE;
        done   = state_q != HALT && last && !stretch;
        // stretch only holds the final count; elsewhere the counter always advances
        cnt_d  = (state_q == HALT || done) ? '0 : last ? cnt_q : cnt_q + ONE;
        phi2_d = state_q != HALT && !done && cnt_d >= (div_q >> 1);
    end
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= HALT;
            cnt_q    <= '0;
            div_q    <= DEF;
            pend_q   <= DEF;
            cyc_q    <= '0;
            phi2_q   <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            ack_q    <= 1'b0;
            halted_q <= 1'b1;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            phi2_q <= phi2_d;
            rise_q <= phi2_d && !phi2_q;
            fall_q <= done;
            ack_q  <= done && state_q == STEP;
            if (done) cyc_q <= cyc_q + CNT_WIDTH'(1);
            // a new divisor only ever lands between cycles
            if (state_q == HALT || done) div_q <= pend_d;
            case (state_q)
                HALT: begin
                    if (run) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end else if (step_req) begin
                        state_q  <= STEP;
                        halted_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (done && !run) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                STEP: begin
                    if (done) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end
    assign phi2        = phi2_q;
    assign phi2_rise   = rise_q;
    assign phi2_fall   = fall_q;
    assign step_ack    = ack_q;
    assign halted      = halted_q;
    assign cycle_count = cyc_q;
endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
Sequencer for the 6502 system clock in the CPLD. Divides the 12 MHz board clock into the CPU phase clock phi2 with a programmable divisor, and stretches the high phase for slow devices. Also provides run/halt/single-step control for the debug monitor. It sits between the oscillator input and the CPU/bus logic and supplies phase-edge strobes to the bus decoder.

Parameters:
DIV_WIDTH, 4, width of divisor and phase counter
DEFAULT_DIV, 12, divisor loaded at reset (12 MHz / 12 = 1 MHz phi2)
CNT_WIDTH, 16, width of completed-cycle counter

Ports:
clk_in  input  1  12 MHz system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  level; 1 = free-run phi2, 0 = halt at end of current cycle
step_req  input  1  one-clk pulse; in HALT, run exactly one phi2 cycle
step_ack  output  1  one-clk pulse when a stepped cycle completes
div_load  input  1  one-clk pulse; capture div_value as pending divisor
div_value  input  DIV_WIDTH  new divisor; values 0 and 1 are clamped to 2
stretch  input  1  wait request from slow device; holds phi2 high
phi2  output  1  registered CPU phase-2 clock
phi2_rise  output  1  high during the first clk_in cycle of each phi2-high phase
phi2_fall  output  1  high during the first clk_in cycle of each phi2-low phase after a completed cycle
halted  output  1  1 while in HALT (phi2 guaranteed low)
cycle_count  output  CNT_WIDTH  number of completed phi2 cycles, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, immediate): state=HALT, cnt=0, div_eff=pending=DEFAULT_DIV. phi2=0, phi2_rise=0, phi2_fall=0, step_ack=0, halted=1, cycle_count=0. Reset asserted mid-cycle truncates phi2 at once and discards any pending divisor.
- States: HALT, RUN, STEP. HALT->RUN when run=1. HALT->STEP when run=0 and step_req=1. run has priority over step_req, and step_req is then ignored with no ack. step_req in RUN or STEP is ignored.
- The transition edge out of HALT is cycle clock 0. cnt counts 0..div_eff-1, and phi2 registers (next cnt >= LOW), where LOW = div_eff>>1 and HIGH = div_eff-LOW. Example: div 12 gives 6 low and 6 high. Div 5 gives 2 low and 3 high.
- Boundary: when cnt==div_eff-1 and stretch=0, the cycle completes. cnt<=0, phi2<=0, cycle_count increments, and div_eff<=pending. If instead stretch=1 at cnt==div_eff-1, cnt and phi2=1 hold, and each held clock extends the high phase by one clk_in. stretch is ignored at all other counts.
- Pending divisor: div_load updates pending on any clock, in any state. The last load before a boundary wins. It takes effect only at a cycle boundary or in HALT, and never alters a cycle in progress. Clamp: div_value<2 loads 2.
- End of cycle in RUN: if run=0 at the boundary, go to HALT and set halted=1 on the next clock. Otherwise start the next cycle with no gap.
- STEP: runs one full cycle, including any stretch. At its boundary, step_ack=1 for one clk and the block returns to HALT. A step_req arriving during STEP is dropped.
- phi2_rise and phi2_fall are registered, aligned with the first clk_in period of the new phi2 level. phi2_fall fires at every completed boundary, including entry to HALT.
- phi2 has no glitches. There are no combinational paths from inputs to outputs.
- cycle_count wraps from 2^CNT_WIDTH-1 to 0 without any flag.

Test Plan:
- Reset released, run=1, default div -> phi2 period 12 clk_in (996 ns at 83 ns clk), 6 low / 6 high. phi2_rise and phi2_fall each pulse once per period. cycle_count=4 after 48 clk_in plus 1.
- div_load div_value=5 mid-cycle -> the current cycle stays 12 clocks. Subsequent cycles are 2 low / 3 high. Then load div_value=1 -> cycles are 1 low / 1 high.
- stretch=1 for 3 clocks covering cnt=11 -> high phase is 9 clocks and the total cycle is 15. cycle_count increments only once.
- run dropped at cnt=3 -> the cycle completes (12 clocks), then halted=1 and phi2 stays 0. A later step_req pulse -> exactly one 12-clock cycle, then a single step_ack pulse, then halted=1.
- step_req and run=1 in the same HALT clock -> enter RUN and step_ack is never asserted. step_req during RUN -> no effect.
- reset asserted while phi2=1 at cnt=8 -> phi2=0 and halted=1 with no clock edge. cycle_count=0 and the divisor reverts to 12.
